decode_queue: RTL and testbench

- Parametrised successor to the single-register IF→ID latch: a DEPTH-entry show-ahead queue between fetch and decode.
- Decouples fetch from backend stalls and predecodes register indices for the regfile read port.
- Adds halt-on-break, and flush that drops all buffered instructions.
- Sits between the fetch stage and the ctrl-bus builder; all handshakes are valid/ready.

---
 rtl/decode_queue_if.sv | 48 ++++
 rtl/decode_queue.sv | 119 +++++++++++
 tb/tb_decode_queue.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_queue_if.sv
// Fetch-to-decode handshake bundle for decode_queue; the queue uses the slave modport.
// Carries stall_cnt only when DQ_STALL_CNT_EN is defined.
interface decode_queue_if #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int INST_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [INST_W-1:0] in_inst;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;
  logic [4:0]        out_reg_index1;
  logic [4:0]        out_reg_index2;
  logic [4:0]        out_wreg_index;
  logic              out_is_break;
  logic [CNT_W-1:0]  count;
  logic              halted;
`ifdef DQ_STALL_CNT_EN
  logic [31:0]       stall_cnt;
`endif

  modport slave (
    input  flush, in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_inst,
    output out_reg_index1, out_reg_index2, out_wreg_index, out_is_break,
`ifdef DQ_STALL_CNT_EN
    output stall_cnt,
`endif
    output count, halted
  );

  modport master (
    output flush, in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_inst,
    input  out_reg_index1, out_reg_index2, out_wreg_index, out_is_break,
`ifdef DQ_STALL_CNT_EN
    input  stall_cnt,
`endif
    input  count, halted
  );
endinterface

// File: rtl/decode_queue.sv
// DEPTH-entry show-ahead queue between fetch and decode with register predecode,
// halt-on-break and flush. Define DQ_STALL_CNT_EN to add the saturating stall_cnt output.
module decode_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  decode_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HALT = 1'b1;

  logic [PC_W-1:0]   pcMem   [DEPTH];
  logic [INST_W-1:0] instMem [DEPTH];

  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [0:0]       state_q, state_d;

  logic              push;
  logic              pop;
  logic [INST_W-1:0] headInst;
  logic [5:0]        headOp;
  logic [3:0]        headSub;
  logic              headStore;
  logic              headBranch;
  logic              headBl;
  logic              headBreak;

  // in_ready looks only at the registered count, so a same-cycle pop never frees a full queue
  assign bus.in_ready  = (count_q != CNT_W'(DEPTH));
  assign bus.out_valid = (count_q != '0) && (state_q == RUN);
  assign push          = bus.in_valid && bus.in_ready && !bus.flush;
  assign pop           = bus.out_valid && bus.out_ready && !bus.flush;

  assign headInst   = instMem[rdPtr_q];
  assign headOp     = headInst[31:26];
  assign headSub    = headInst[25:22];
  assign headStore  = (headOp == 6'h0a) &&
                      ((headSub == 4'd4) || (headSub == 4'd5) || (headSub == 4'd6));
  assign headBranch = (headOp >= 6'h16) && (headOp <= 6'h1b);
  assign headBl     = (headOp == 6'h15);
  assign headBreak  = (headInst[31:15] == 17'h00054);

  assign bus.out_pc         = pcMem[rdPtr_q];
  assign bus.out_inst       = headInst;
  assign bus.out_reg_index1 = headInst[9:5];
  assign bus.out_reg_index2 = (headStore || headBranch) ? headInst[4:0] : headInst[14:10];
  assign bus.out_wreg_index = headBl ? 5'h01 : headInst[4:0];
  assign bus.out_is_break   = headBreak;
  assign bus.count          = count_q;
  assign bus.halted         = (state_q == HALT);

  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    state_d = state_q;
    if (bus.flush) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
      state_d = RUN;
    end else begin
      if (push) wrPtr_d = wrPtr_q + PTR_W'(1);
      if (pop)  rdPtr_d = rdPtr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (pop && headBreak) state_d = HALT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
      state_q <= RUN;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  // Storage carries no reset; count gates every read of it
  always_ff @(posedge clk) begin
    if (push) begin
      pcMem[wrPtr_q]   <= bus.in_pc;
      instMem[wrPtr_q] <= bus.in_inst;
    end
  end

`ifdef DQ_STALL_CNT_EN
  logic [31:0] stallCnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCnt_q <= '0;
    end else if (bus.in_valid && !bus.in_ready && (stallCnt_q != 32'hFFFF_FFFF)) begin
      stallCnt_q <= stallCnt_q + 32'd1;
    end
  end

  assign bus.stall_cnt = stallCnt_q;
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: stimulus queues accepted entries, a monitor checks the head.
// Define DQ_STALL_CNT_EN to also exercise the stall counter.
module tb_decode_queue;

  localparam int DEPTH  = 4;
  localparam int PC_W   = 32;
  localparam int INST_W = 32;

  localparam logic [31:0] ST_W  = 32'h29800C85;
  localparam logic [31:0] ADD_W = 32'h00101885;
  localparam logic [31:0] BL_I  = 32'h54000400;
  localparam logic [31:0] BRK_I = 32'h002A0000;
  localparam logic [31:0] ADDI  = 32'h02800421;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  decode_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) tif ();

  decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (tif)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t sbq[$];
  bit     mHalted = 1'b0;
  bit     pushNow = 1'b0;
  bit     done    = 1'b0;
  int     checkCount = 0;
  int     passCount  = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference predecode straight from the instruction-field rules
  function automatic bit refNeedsRd(input logic [31:0] inst);
    int op  = int'(inst[31:26]);
    int sub = int'(inst[25:22]);
    return ((op == 10) && (sub >= 4) && (sub <= 6)) || ((op >= 22) && (op <= 27));
  endfunction

  function automatic logic [4:0] refIdx2(input logic [31:0] inst);
    return refNeedsRd(inst) ? inst[4:0] : inst[14:10];
  endfunction

  function automatic logic [4:0] refWreg(input logic [31:0] inst);
    return (int'(inst[31:26]) == 21) ? 5'd1 : inst[4:0];
  endfunction

  function automatic bit refIsBreak(input logic [31:0] inst);
    return (inst >> 15) == 32'h54;
  endfunction

  task automatic applyStimulus(input bit v, input logic [31:0] pc, input logic [31:0] inst,
                               input bit rdy, input bit fl);
    entry_t e;
    @(negedge clk);
    tif.in_valid  = v;
    tif.in_pc     = pc;
    tif.in_inst   = inst;
    tif.out_ready = rdy;
    tif.flush     = fl;
    pushNow       = 1'b0;
    #1;
    if (v && !fl && (sbq.size() < DEPTH)) begin
      e.pc   = pc;
      e.inst = inst;
      sbq.push_back(e);
      pushNow = 1'b1;
    end
  endtask

  task automatic doReset();
    reset         = 1'b0;
    tif.in_valid  = 1'b0;
    tif.out_ready = 1'b0;
    tif.flush     = 1'b0;
    tif.in_pc     = '0;
    tif.in_inst   = '0;
    pushNow       = 1'b0;
    sbq.delete();
    mHalted = 1'b0;
    #1;
    checkOutput("reset_count", 64'(tif.count), 64'd0);
    checkOutput("reset_out_valid", 64'(tif.out_valid), 64'd0);
    checkOutput("reset_in_ready", 64'(tif.in_ready), 64'd1);
    checkOutput("reset_halted", 64'(tif.halted), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: compares the DUT against the scoreboard model once per cycle
  initial begin : monitor
    entry_t e;
    int     expCount;
    bit     expValid;
    while (!done) begin
      @(negedge clk);
      #2;
      if (reset && !done) begin
        expCount = sbq.size() - int'(pushNow);
        expValid = (expCount > 0) && !mHalted;
        checkOutput("count", 64'(tif.count), 64'(expCount));
        checkOutput("in_ready", 64'(tif.in_ready), 64'(expCount < DEPTH));
        checkOutput("out_valid", 64'(tif.out_valid), 64'(expValid));
        checkOutput("halted", 64'(tif.halted), 64'(mHalted));
        if (expValid) begin
          e = sbq[0];
          checkOutput("out_pc", 64'(tif.out_pc), 64'(e.pc));
          checkOutput("out_inst", 64'(tif.out_inst), 64'(e.inst));
          checkOutput("reg_index1", 64'(tif.out_reg_index1), 64'(e.inst[9:5]));
          checkOutput("reg_index2", 64'(tif.out_reg_index2), 64'(refIdx2(e.inst)));
          checkOutput("wreg_index", 64'(tif.out_wreg_index), 64'(refWreg(e.inst)));
          checkOutput("is_break", 64'(tif.out_is_break), 64'(refIsBreak(e.inst)));
        end
        if (tif.flush) begin
          sbq.delete();
          mHalted = 1'b0;
        end else if (expValid && tif.out_ready) begin
          e = sbq.pop_front();
          if (refIsBreak(e.inst)) mHalted = 1'b1;
        end
      end
    end
  end

  initial begin : stimulus
    logic [31:0] inst;
    doReset();

    // Fill then drain
    for (int i = 0; i < 4; i++) applyStimulus(1, 32'h1c000000 + 32'(4 * i), ADD_W, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("full_count", 64'(tif.count), 64'd4);
    checkOutput("full_in_ready", 64'(tif.in_ready), 64'd0);
    applyStimulus(1, 32'h1c0000f0, ADD_W, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("drained_count", 64'(tif.count), 64'd0);
    checkOutput("drained_out_valid", 64'(tif.out_valid), 64'd0);

    // Concurrent push/pop around count 2
    applyStimulus(1, 32'h1c000010, ADD_W, 0, 0);
    applyStimulus(1, 32'h1c000014, ST_W, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(1, 32'h1c000018 + 32'(4 * i), BL_I, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("steady_count", 64'(tif.count), 64'd2);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);

    // Predecode on known encodings
    applyStimulus(1, 32'h1c000100, ST_W, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("st_index1", 64'(tif.out_reg_index1), 64'd4);
    checkOutput("st_index2", 64'(tif.out_reg_index2), 64'd5);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(1, 32'h1c000104, ADD_W, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("add_index2", 64'(tif.out_reg_index2), 64'd6);
    checkOutput("add_wreg", 64'(tif.out_wreg_index), 64'd5);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(1, 32'h1c000108, BL_I, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("bl_wreg", 64'(tif.out_wreg_index), 64'd1);
    applyStimulus(0, 0, 0, 1, 0);

    // Break halts the output until flush
    applyStimulus(1, 32'h1c000200, ADD_W, 0, 0);
    applyStimulus(1, 32'h1c000204, BRK_I, 0, 0);
    applyStimulus(1, 32'h1c000208, ADDI, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0);
    checkOutput("brk_halted", 64'(tif.halted), 64'd1);
    checkOutput("brk_out_valid", 64'(tif.out_valid), 64'd0);
    checkOutput("brk_count", 64'(tif.count), 64'd1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("flush_count", 64'(tif.count), 64'd0);
    checkOutput("flush_halted", 64'(tif.halted), 64'd0);

    // Flush discards a same-cycle push and pop
    for (int i = 0; i < 3; i++) applyStimulus(1, 32'h1c000300 + 32'(4 * i), ADD_W, 0, 0);
    applyStimulus(1, 32'hdead0000, ADDI, 1, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("flushpush_count", 64'(tif.count), 64'd0);
    applyStimulus(1, 32'h1c000400, ST_W, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);

    // Asynchronous reset mid-cycle at count 2
    applyStimulus(1, 32'h1c000500, ADD_W, 0, 0);
    applyStimulus(1, 32'h1c000504, ADD_W, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("prereset_count", 64'(tif.count), 64'd2);
    #2;
    doReset();

`ifdef DQ_STALL_CNT_EN
    for (int i = 0; i < 4; i++) applyStimulus(1, 32'h1c000600 + 32'(4 * i), ADD_W, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 32'h1c000700, ADD_W, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("stall_cnt", 64'(tif.stall_cnt), 64'd5);
    applyStimulus(0, 0, 0, 0, 1);
`endif

    // Randomised traffic against the scoreboard
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 7))
        0:       inst = ST_W;
        1:       inst = ADD_W;
        2:       inst = BL_I;
        3:       inst = ($urandom_range(0, 2) == 0) ? BRK_I : ADDI;
        4:       inst = {6'(22 + $urandom_range(0, 5)), 26'($urandom())};
        default: inst = $urandom();
      endcase
      applyStimulus(1'($urandom_range(0, 1)), $urandom(), inst,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end

    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    done = 1'b1;
    @(negedge clk);
    #3;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
